gpr_csr_file: RTL and testbench

Architectural state responder for the register-fetch stage. It serves the combinational read requests for rs1, rs2 and a CSR address, and takes retire-time writes from the write-back stage. It also applies the trap-entry and mret state updates. It supplies the redirect targets (mtvec, mepc) to the flush logic.

---
 rtl/gpr_csr_file_pkg.sv | 41 ++++
 rtl/gpr_csr_file_csr_file.sv | 115 +++++++++++
 rtl/gpr_csr_file.sv | 83 ++++++++
 tb/tb_gpr_csr_file.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_csr_file_pkg.sv
// ============================================================================
// Module      : gpr_csr_file_pkg
// Description : Shared CSR addresses, mstatus bit positions and reset values
//               for the architectural register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpr_csr_file_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT    = 3;
    localparam int MSTATUS_MPIE_BIT   = 7;
    localparam int MSTATUS_MPP_LO_BIT = 11;
    localparam int MSTATUS_MPP_HI_BIT = 12;

    // Only machine mode exists, so MPP is hard-wired to M
    localparam logic [1:0] MPP_MACHINE = 2'b11;

    // Assemble the architectural mstatus view from the two stored bits
    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] v;
        v = '0;
        v[MSTATUS_MIE_BIT]                       = mie;
        v[MSTATUS_MPIE_BIT]                      = mpie;
        v[MSTATUS_MPP_HI_BIT:MSTATUS_MPP_LO_BIT] = MPP_MACHINE;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpr_csr_file_csr_file.sv
// ============================================================================
// Module      : csr_file
// Description : Machine-mode CSR storage, combinational read mux, trap-entry
//               and mret updates with per-CSR priority resolution.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_file
    import gpr_csr_file_pkg::*;
#(
    parameter logic [31:0] MVENDORID = 32'h7973_7978,
    parameter logic [31:0] MARCHID   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] csr_raddr_i,
    output logic [31:0] csr_rvalue_o,
    input  logic        wbu_valid_i,
    input  logic        wbu_csr_we_i,
    input  logic [11:0] wbu_csr_addr_i,
    input  logic [31:0] wbu_csr_wdata_i,
    input  logic        excp_valid_i,
    input  logic [31:0] excp_pc_i,
    input  logic [4:0]  excp_cause_i,
    input  logic        mret_valid_i,
    output logic [31:0] trap_target_o,
    output logic [31:0] mret_target_o,
    output logic        mstatus_mie_o
);

    // Only the bits that can ever be non-zero are stored; the low two bits of
    // mtvec and mepc are architecturally zero.
    logic        r_mie;
    logic        r_mpie;
    logic [31:2] r_mtvec;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mscratch;

    logic        w_csr_wr;
    logic        w_unused_pc_lsbs;

    assign w_csr_wr         = wbu_valid_i && wbu_csr_we_i;
    // mepc is word aligned, so the incoming PC's low bits are dropped
    assign w_unused_pc_lsbs = ^excp_pc_i[1:0];

    // CSR state update: reset > trap > mret > write-back write, resolved per CSR
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mscratch <= '0;
        end else begin
            // mstatus: trap and mret both own MIE/MPIE
            if (excp_valid_i) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
            end else if (mret_valid_i) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_csr_wr && wbu_csr_addr_i == CSR_MSTATUS) begin
                r_mie  <= wbu_csr_wdata_i[MSTATUS_MIE_BIT];
                r_mpie <= wbu_csr_wdata_i[MSTATUS_MPIE_BIT];
            end

            // mepc and mcause are captured on trap entry; mret leaves them alone
            if (excp_valid_i) begin
                r_mepc <= excp_pc_i[31:2];
            end else if (w_csr_wr && wbu_csr_addr_i == CSR_MEPC) begin
                r_mepc <= wbu_csr_wdata_i[31:2];
            end

            if (excp_valid_i) begin
                r_mcause <= {27'b0, excp_cause_i};
            end else if (w_csr_wr && wbu_csr_addr_i == CSR_MCAUSE) begin
                r_mcause <= wbu_csr_wdata_i;
            end

            // mtvec and mscratch are untouched by trap/mret, so writes always land
            if (w_csr_wr && wbu_csr_addr_i == CSR_MTVEC) begin
                r_mtvec <= wbu_csr_wdata_i[31:2];
            end

            if (w_csr_wr && wbu_csr_addr_i == CSR_MSCRATCH) begin
                r_mscratch <= wbu_csr_wdata_i;
            end
        end
    end

    // Combinational read mux; unimplemented addresses read zero
    always_comb begin
        csr_rvalue_o = '0;
        case (csr_raddr_i)
            CSR_MSTATUS:   csr_rvalue_o = mstatus_pack(r_mie, r_mpie);
            CSR_MTVEC:     csr_rvalue_o = {r_mtvec, 2'b00};
            CSR_MSCRATCH:  csr_rvalue_o = r_mscratch;
            CSR_MEPC:      csr_rvalue_o = {r_mepc, 2'b00};
            CSR_MCAUSE:    csr_rvalue_o = r_mcause;
            CSR_MVENDORID: csr_rvalue_o = MVENDORID;
            CSR_MARCHID:   csr_rvalue_o = MARCHID;
            default:       csr_rvalue_o = '0;
        endcase
    end

    assign trap_target_o = {r_mtvec, 2'b00};
    assign mret_target_o = {r_mepc, 2'b00};
    assign mstatus_mie_o = r_mie;

endmodule

`default_nettype wire

// File: rtl/gpr_csr_file.sv
// ============================================================================
// Module      : gpr_csr_file
// Description : Architectural state for the register-fetch stage: 32 GPRs
//               with two combinational read ports plus the machine CSRs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_csr_file
    import gpr_csr_file_pkg::*;
#(
    parameter logic [31:0] MVENDORID = 32'h7973_7978,
    parameter logic [31:0] MARCHID   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] rs1_value_o,
    output logic [31:0] rs2_value_o,
    input  logic [11:0] csr_raddr_i,
    output logic [31:0] csr_rvalue_o,
    input  logic        wbu_valid_i,
    input  logic        wbu_gr_we_i,
    input  logic [4:0]  wbu_rd_i,
    input  logic [31:0] wbu_wdata_i,
    input  logic        wbu_csr_we_i,
    input  logic [11:0] wbu_csr_addr_i,
    input  logic [31:0] wbu_csr_wdata_i,
    input  logic        excp_valid_i,
    input  logic [31:0] excp_pc_i,
    input  logic [4:0]  excp_cause_i,
    input  logic        mret_valid_i,
    output logic [31:0] trap_target_o,
    output logic [31:0] mret_target_o,
    output logic        mstatus_mie_o
);

    // Entry 0 is never written after reset; reads of x0 are also forced to 0
    logic [31:0] r_gpr [32];
    logic        w_gpr_wr;

    assign w_gpr_wr = wbu_valid_i && wbu_gr_we_i && (wbu_rd_i != 5'd0);

    // GPR array: reset clears everything, otherwise one retire-time write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_gpr_wr) begin
            r_gpr[wbu_rd_i] <= wbu_wdata_i;
        end
    end

    // No write-to-read bypass: the fetch stage stalls on write-back hazards
    assign rs1_value_o = (rs1_i == 5'd0) ? 32'd0 : r_gpr[rs1_i];
    assign rs2_value_o = (rs2_i == 5'd0) ? 32'd0 : r_gpr[rs2_i];

    csr_file #(
        .MVENDORID (MVENDORID),
        .MARCHID   (MARCHID)
    ) u_csr_file (
        .clock           (clock),
        .reset           (reset),
        .csr_raddr_i     (csr_raddr_i),
        .csr_rvalue_o    (csr_rvalue_o),
        .wbu_valid_i     (wbu_valid_i),
        .wbu_csr_we_i    (wbu_csr_we_i),
        .wbu_csr_addr_i  (wbu_csr_addr_i),
        .wbu_csr_wdata_i (wbu_csr_wdata_i),
        .excp_valid_i    (excp_valid_i),
        .excp_pc_i       (excp_pc_i),
        .excp_cause_i    (excp_cause_i),
        .mret_valid_i    (mret_valid_i),
        .trap_target_o   (trap_target_o),
        .mret_target_o   (mret_target_o),
        .mstatus_mie_o   (mstatus_mie_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_gpr_csr_file.sv
// ============================================================================
// Module      : tb_gpr_csr_file
// Description : Directed, table-driven self-checking bench for gpr_csr_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpr_csr_file;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs1_i, rs2_i;
    logic [31:0] rs1_value_o, rs2_value_o;
    logic [11:0] csr_raddr_i;
    logic [31:0] csr_rvalue_o;
    logic        wbu_valid_i, wbu_gr_we_i, wbu_csr_we_i;
    logic [4:0]  wbu_rd_i;
    logic [31:0] wbu_wdata_i;
    logic [11:0] wbu_csr_addr_i;
    logic [31:0] wbu_csr_wdata_i;
    logic        excp_valid_i, mret_valid_i;
    logic [31:0] excp_pc_i;
    logic [4:0]  excp_cause_i;
    logic [31:0] trap_target_o, mret_target_o;
    logic        mstatus_mie_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    gpr_csr_file dut (
        .clock           (clock),
        .reset           (reset),
        .rs1_i           (rs1_i),
        .rs2_i           (rs2_i),
        .rs1_value_o     (rs1_value_o),
        .rs2_value_o     (rs2_value_o),
        .csr_raddr_i     (csr_raddr_i),
        .csr_rvalue_o    (csr_rvalue_o),
        .wbu_valid_i     (wbu_valid_i),
        .wbu_gr_we_i     (wbu_gr_we_i),
        .wbu_rd_i        (wbu_rd_i),
        .wbu_wdata_i     (wbu_wdata_i),
        .wbu_csr_we_i    (wbu_csr_we_i),
        .wbu_csr_addr_i  (wbu_csr_addr_i),
        .wbu_csr_wdata_i (wbu_csr_wdata_i),
        .excp_valid_i    (excp_valid_i),
        .excp_pc_i       (excp_pc_i),
        .excp_cause_i    (excp_cause_i),
        .mret_valid_i    (mret_valid_i),
        .trap_target_o   (trap_target_o),
        .mret_target_o   (mret_target_o),
        .mstatus_mie_o   (mstatus_mie_o)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic        gr_we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        csr_we;
        logic [11:0] caddr;
        logic [31:0] cwdata;
        logic        excp;
        logic [31:0] pc;
        logic [4:0]  cause;
        logic        mret;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] craddr;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_csr;
        logic [31:0] e_trap;
        logic [31:0] e_mret;
        logic        e_mie;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wbu_valid_i     = 1'b0;
        wbu_gr_we_i     = 1'b0;
        wbu_rd_i        = '0;
        wbu_wdata_i     = '0;
        wbu_csr_we_i    = 1'b0;
        wbu_csr_addr_i  = '0;
        wbu_csr_wdata_i = '0;
        excp_valid_i    = 1'b0;
        excp_pc_i       = '0;
        excp_cause_i    = '0;
        mret_valid_i    = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        rs1_i       = '0;
        rs2_i       = '0;
        csr_raddr_i = '0;
        idle_inputs();

        // name, valid, gr_we, rd, wdata, csr_we, caddr, cwdata, excp, pc, cause, mret,
        // rs1, rs2, craddr, e_rs1, e_rs2, e_csr, e_trap, e_mret, e_mie
        vq.push_back('{"x0_write",      1,1, 0,32'h0000_1234, 0,12'h000,32'h0,         0,32'h0,         5'd0, 0,  0, 5,12'h300, 32'h0,        32'hDEAD_BEEF,32'h0000_1800,32'h0,        32'h0,        0});
        vq.push_back('{"mtvec_mask",    1,0, 0,32'h0,         1,12'h305,32'h8000_0003, 0,32'h0,         5'd0, 0,  5, 0,12'h305, 32'hDEAD_BEEF,32'h0,        32'h8000_0000,32'h8000_0000,32'h0,        0});
        vq.push_back('{"mstatus_ones",  1,0, 0,32'h0,         1,12'h300,32'hFFFF_FFFF, 0,32'h0,         5'd0, 0,  5, 5,12'h300, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_1888,32'h8000_0000,32'h0,        1});
        vq.push_back('{"mvendorid_ro",  1,0, 0,32'h0,         1,12'hF11,32'h0,         0,32'h0,         5'd0, 0,  5, 5,12'hF11, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h7973_7978,32'h8000_0000,32'h0,        1});
        vq.push_back('{"marchid",       0,0, 0,32'h0,         0,12'h000,32'h0,         0,32'h0,         5'd0, 0,  5, 5,12'hF12, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0,        32'h8000_0000,32'h0,        1});
        vq.push_back('{"mstatus_mie",   1,0, 0,32'h0,         1,12'h300,32'h0000_0008, 0,32'h0,         5'd0, 0,  5, 5,12'h300, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_1808,32'h8000_0000,32'h0,        1});
        vq.push_back('{"trap_mepc",     0,0, 0,32'h0,         0,12'h000,32'h0,         1,32'h8000_0102, 5'd11,0,  5, 5,12'h341, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h8000_0100,32'h8000_0000,32'h8000_0100,0});
        vq.push_back('{"trap_mcause",   0,0, 0,32'h0,         0,12'h000,32'h0,         0,32'h0,         5'd0, 0,  5, 5,12'h342, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_000B,32'h8000_0000,32'h8000_0100,0});
        vq.push_back('{"trap_mstatus",  0,0, 0,32'h0,         0,12'h000,32'h0,         0,32'h0,         5'd0, 0,  5, 5,12'h300, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_1880,32'h8000_0000,32'h8000_0100,0});
        vq.push_back('{"mret",          0,0, 0,32'h0,         0,12'h000,32'h0,         0,32'h0,         5'd0, 1,  5, 5,12'h300, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_1888,32'h8000_0000,32'h8000_0100,1});
        vq.push_back('{"excp_mret_wb",  1,0, 0,32'h0,         1,12'h341,32'h0000_0055, 1,32'h0000_0204, 5'd2, 1,  5, 5,12'h341, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_0204,32'h8000_0000,32'h0000_0204,0});
        vq.push_back('{"coll_mstatus",  0,0, 0,32'h0,         0,12'h000,32'h0,         0,32'h0,         5'd0, 0,  5, 5,12'h300, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_1880,32'h8000_0000,32'h0000_0204,0});
        vq.push_back('{"coll_mcause",   0,0, 0,32'h0,         0,12'h000,32'h0,         0,32'h0,         5'd0, 0,  5, 5,12'h342, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_0002,32'h8000_0000,32'h0000_0204,0});
        vq.push_back('{"excp_mscratch", 1,0, 0,32'h0,         1,12'h340,32'h0000_0077, 1,32'h0000_0300, 5'd7, 0,  5, 5,12'h340, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_0077,32'h8000_0000,32'h0000_0300,0});
        vq.push_back('{"coll2_mstatus", 0,0, 0,32'h0,         0,12'h000,32'h0,         0,32'h0,         5'd0, 0,  5, 5,12'h300, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_1800,32'h8000_0000,32'h0000_0300,0});
        vq.push_back('{"invalid_wb",    0,1, 5,32'h0,         1,12'h340,32'h0000_0099, 0,32'h0,         5'd0, 0,  5, 5,12'h340, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_0077,32'h8000_0000,32'h0000_0300,0});
        vq.push_back('{"unimpl_csr",    1,0, 0,32'h0,         1,12'h7C0,32'h0000_FFFF, 0,32'h0,         5'd0, 0,  5, 5,12'h7C0, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0,        32'h8000_0000,32'h0000_0300,0});
        vq.push_back('{"mepc_mask",     1,0, 0,32'h0,         1,12'h341,32'h0000_1237, 0,32'h0,         5'd0, 0,  5, 5,12'h341, 32'hDEAD_BEEF,32'hDEAD_BEEF,32'h0000_1234,32'h8000_0000,32'h0000_1234,0});
        vq.push_back('{"x31_write",     1,1,31,32'hA5A5_A5A5, 0,12'h000,32'h0,         0,32'h0,         5'd0, 0, 31, 5,12'h305, 32'hA5A5_A5A5,32'hDEAD_BEEF,32'h8000_0000,32'h8000_0000,32'h0000_1234,0});

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        reset       = 1'b0;
        rs1_i       = 5'd5;
        rs2_i       = 5'd31;
        csr_raddr_i = 12'h300;
        #1;
        check("rst_rs1", rs1_value_o, 32'h0);
        check("rst_rs2", rs2_value_o, 32'h0);
        check("rst_mstatus", csr_rvalue_o, 32'h0000_1800);
        check("rst_trap", trap_target_o, 32'h0);
        check("rst_mret", mret_target_o, 32'h0);
        check("rst_mie", {31'b0, mstatus_mie_o}, 32'h0);

        // Same-cycle write and read of x5: old value now, new value next cycle
        wbu_valid_i = 1'b1;
        wbu_gr_we_i = 1'b1;
        wbu_rd_i    = 5'd5;
        wbu_wdata_i = 32'hDEAD_BEEF;
        #1;
        check("no_bypass_old", rs1_value_o, 32'h0);
        @(posedge clock);
        #1;
        idle_inputs();
        #1;
        check("no_bypass_new", rs1_value_o, 32'hDEAD_BEEF);

        // Table-driven vectors: apply for one edge, then inspect
        foreach (vq[k]) begin
            wbu_valid_i     = vq[k].valid;
            wbu_gr_we_i     = vq[k].gr_we;
            wbu_rd_i        = vq[k].rd;
            wbu_wdata_i     = vq[k].wdata;
            wbu_csr_we_i    = vq[k].csr_we;
            wbu_csr_addr_i  = vq[k].caddr;
            wbu_csr_wdata_i = vq[k].cwdata;
            excp_valid_i    = vq[k].excp;
            excp_pc_i       = vq[k].pc;
            excp_cause_i    = vq[k].cause;
            mret_valid_i    = vq[k].mret;
            @(posedge clock);
            #1;
            idle_inputs();
            rs1_i       = vq[k].rs1;
            rs2_i       = vq[k].rs2;
            csr_raddr_i = vq[k].craddr;
            #1;
            check({vq[k].name, ".rs1"},  rs1_value_o,   vq[k].e_rs1);
            check({vq[k].name, ".rs2"},  rs2_value_o,   vq[k].e_rs2);
            check({vq[k].name, ".csr"},  csr_rvalue_o,  vq[k].e_csr);
            check({vq[k].name, ".trap"}, trap_target_o, vq[k].e_trap);
            check({vq[k].name, ".mret"}, mret_target_o, vq[k].e_mret);
            check({vq[k].name, ".mie"},  {31'b0, mstatus_mie_o}, {31'b0, vq[k].e_mie});
        end

        // Re-enable MIE so the mid-stream reset has something to clear
        wbu_valid_i     = 1'b1;
        wbu_csr_we_i    = 1'b1;
        wbu_csr_addr_i  = 12'h300;
        wbu_csr_wdata_i = 32'h0000_0088;
        @(posedge clock);
        #1;
        idle_inputs();
        #1;
        check("pre_rst_mie", {31'b0, mstatus_mie_o}, 32'h1);

        // Reset together with a GPR write, a CSR write and a trap
        reset           = 1'b1;
        wbu_valid_i     = 1'b1;
        wbu_gr_we_i     = 1'b1;
        wbu_rd_i        = 5'd7;
        wbu_wdata_i     = 32'h0000_0011;
        wbu_csr_we_i    = 1'b1;
        wbu_csr_addr_i  = 12'h340;
        wbu_csr_wdata_i = 32'h0000_00AA;
        excp_valid_i    = 1'b1;
        excp_pc_i       = 32'h0000_4000;
        excp_cause_i    = 5'd3;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_inputs();
        rs1_i       = 5'd7;
        rs2_i       = 5'd5;
        csr_raddr_i = 12'h300;
        #1;
        check("mid_rst_x7", rs1_value_o, 32'h0);
        check("mid_rst_x5", rs2_value_o, 32'h0);
        check("mid_rst_mstatus", csr_rvalue_o, 32'h0000_1800);
        check("mid_rst_mepc", mret_target_o, 32'h0);
        check("mid_rst_mtvec", trap_target_o, 32'h0);
        check("mid_rst_mie", {31'b0, mstatus_mie_o}, 32'h0);
        rs1_i       = 5'd31;
        csr_raddr_i = 12'h340;
        #1;
        check("mid_rst_x31", rs1_value_o, 32'h0);
        check("mid_rst_mscratch", csr_rvalue_o, 32'h0);
        csr_raddr_i = 12'h342;
        #1;
        check("mid_rst_mcause", csr_rvalue_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
